// File: rtl/sha1_pkg.sv
// Shared types and widths for the SHA-1 block-alignment/hash front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha1_pkg;

    localparam int SHA1_DATA_W = 512;
    localparam int SHA1_KEEP_W = SHA1_DATA_W / 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sha1_stream_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit searched circularly from last+1.
// Latency: purely combinational.
// Backpressure: none; it only selects, the caller decides when to register the pick.
// Ports: req (request vector), last (previous winner), gnt_idx (winner), any (some req set).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any
);

    // Offsets 1..NUM_REQ visit last+1 first and last itself last, so the
    // previous winner only wins again when nobody else is asking.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = int'(last) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sha1_stream_arbiter.sv
// Packet-level round-robin arbiter merging NUM_REQ AXI-Stream sources into one tagged stream.
// Latency: one IDLE bubble per packet to pick, then beats pass through combinationally.
// Backpressure: i_tready_out is routed straight to the granted source only; others see ready=0.
// Ports: clk/reset_n; per-requester tvalid/tdata/tkeep/tlast in and tready out; one merged
//        output stream with o_tid_out source tag; o_busy while a packet is locked; o_pkt_cnt.
module sha1_stream_arbiter
    import sha1_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = SHA1_DATA_W,
    parameter int KEEP_W  = SHA1_KEEP_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic [NUM_REQ-1:0]        o_tready_in,
    input  logic [NUM_REQ-1:0]        i_tvalid_in,
    input  logic [NUM_REQ*DATA_W-1:0] i_tdata_in,
    input  logic [NUM_REQ*KEEP_W-1:0] i_tkeep_in,
    input  logic [NUM_REQ-1:0]        i_tlast_in,
    input  logic                      i_tready_out,
    output logic                      o_tvalid_out,
    output logic [DATA_W-1:0]         o_tdata_out,
    output logic [KEEP_W-1:0]         o_tkeep_out,
    output logic                      o_tlast_out,
    output logic [ID_W-1:0]           o_tid_out,
    output logic                      o_busy,
    output logic [31:0]               o_pkt_cnt
);

    arb_state_t      state;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] pick_idx;
    logic            pick_any;
    logic            locked;
    logic            eop_xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (i_tvalid_in),
        .last    (last_grant),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign locked   = (state == ARB_LOCK);
    assign eop_xfer = o_tvalid_out && i_tready_out && o_tlast_out;

    // Pass-through of the granted port; gated by state so IDLE (and reset,
    // which forces IDLE asynchronously) presents a quiet interface.
    always_comb begin
        o_tready_in = '0;
        if (locked) begin
            o_tready_in[grant] = i_tready_out;
        end
    end

    assign o_tvalid_out = locked && i_tvalid_in[grant];
    assign o_tlast_out  = locked && i_tlast_in[grant];
    assign o_tdata_out  = i_tdata_in[int'(grant)*DATA_W +: DATA_W];
    assign o_tkeep_out  = i_tkeep_in[int'(grant)*KEEP_W +: KEEP_W];
    assign o_tid_out    = locked ? grant : '0;
    assign o_busy       = locked;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            o_pkt_cnt  <= '0;
        end else if (state == ARB_IDLE) begin
            if (pick_any) begin
                grant <= pick_idx;
                state <= ARB_LOCK;
            end
        end else begin
            // Grant is held across source stalls and backpressure; only the
            // tlast handshake releases it.
            if (eop_xfer) begin
                last_grant <= grant;
                o_pkt_cnt  <= o_pkt_cnt + 32'd1;
                state      <= ARB_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_sha1_stream_arbiter.sv
module tb_sha1_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 512;
    localparam int KW = 64;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      o_tready_in;
    logic [N-1:0]      i_tvalid_in = '0;
    logic [N*DW-1:0]   i_tdata_in = '0;
    logic [N*KW-1:0]   i_tkeep_in = '0;
    logic [N-1:0]      i_tlast_in = '0;
    logic              i_tready_out = 1'b0;
    logic              o_tvalid_out;
    logic [DW-1:0]     o_tdata_out;
    logic [KW-1:0]     o_tkeep_out;
    logic              o_tlast_out;
    logic [IW-1:0]     o_tid_out;
    logic              o_busy;
    logic [31:0]       o_pkt_cnt;

    sha1_stream_arbiter #(.NUM_REQ(N), .DATA_W(DW), .KEEP_W(KW), .ID_W(IW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .o_tready_in  (o_tready_in),
        .i_tvalid_in  (i_tvalid_in),
        .i_tdata_in   (i_tdata_in),
        .i_tkeep_in   (i_tkeep_in),
        .i_tlast_in   (i_tlast_in),
        .i_tready_out (i_tready_out),
        .o_tvalid_out (o_tvalid_out),
        .o_tdata_out  (o_tdata_out),
        .o_tkeep_out  (o_tkeep_out),
        .o_tlast_out  (o_tlast_out),
        .o_tid_out    (o_tid_out),
        .o_busy       (o_busy),
        .o_pkt_cnt    (o_pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Source-side state: each port walks through packets beat by beat and
    // obeys AXI: an offered beat is held until it is accepted.
    int           rem  [N];
    logic         vld  [N];
    logic [DW-1:0] dat [N];
    logic [KW-1:0] kep [N];
    logic         lst  [N];
    logic         xfer [N];

    // Reference: who owns the output (-1 = nobody), who finished last, packets done.
    int owner;
    int prev;
    int pkts;
    int tid_order[$];

    bit all_valid;   // every port always has a 2-beat packet ready, sink always ready

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic apply_inputs();
        for (int k = 0; k < N; k++) begin
            i_tvalid_in[k]          = vld[k];
            i_tlast_in[k]           = lst[k];
            i_tdata_in[k*DW +: DW]  = dat[k];
            i_tkeep_in[k*KW +: KW]  = kep[k];
        end
    endtask

    task automatic clear_sources();
        for (int k = 0; k < N; k++) begin
            rem[k] = 0; vld[k] = 1'b0; lst[k] = 1'b0; xfer[k] = 1'b0;
            dat[k] = '0; kep[k] = '0;
        end
        apply_inputs();
    endtask

    task automatic model_reset();
        owner = -1;
        prev  = N - 1;
        pkts  = 0;
    endtask

    // Runs just after a rising edge: retire accepted beats, offer new ones.
    task automatic drive_sources();
        for (int k = 0; k < N; k++) begin
            if (xfer[k]) begin
                rem[k]--;
                vld[k] = 1'b0;
            end
            if (!vld[k]) begin
                if (rem[k] == 0 && (all_valid || $urandom_range(0, 3) == 0))
                    rem[k] = all_valid ? 2 : int'($urandom_range(1, 4));
                // Gaps between beats of a packet model a mid-packet source stall.
                if (rem[k] > 0 && (all_valid || $urandom_range(0, 2) != 0)) begin
                    vld[k] = 1'b1;
                    dat[k] = rand_data();
                    kep[k] = (rem[k] == 1 && $urandom_range(0, 1) == 1) ? 64'h0000_0000_FFFF_FFFF
                                                                         : {$urandom, $urandom};
                    lst[k] = (rem[k] == 1);
                end
            end
        end
        apply_inputs();
        i_tready_out = all_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    // Runs on the falling edge: compare outputs against the reference, then
    // advance the reference across the coming rising edge.
    task automatic check_and_step();
        logic [N-1:0] exp_rdy;
        logic         exp_vld;
        exp_rdy = '0;
        exp_vld = 1'b0;
        if (owner >= 0) begin
            exp_vld = vld[owner];
            exp_rdy[owner] = i_tready_out;
        end
        chk("tvalid_out", DW'(o_tvalid_out), DW'(exp_vld));
        chk("tready_in", DW'(o_tready_in), DW'(exp_rdy));
        chk("busy", DW'(o_busy), DW'(owner >= 0));
        chk("pkt_cnt", DW'(o_pkt_cnt), DW'(pkts));
        if (exp_vld) begin
            chk("tdata", o_tdata_out, dat[owner]);
            chk("tkeep", DW'(o_tkeep_out), DW'(kep[owner]));
            chk("tlast", DW'(o_tlast_out), DW'(lst[owner]));
            chk("tid", DW'(o_tid_out), DW'(owner));
        end

        for (int k = 0; k < N; k++) xfer[k] = 1'b0;
        if (owner < 0) begin
            for (int off = 1; off <= N; off++) begin
                if (owner < 0 && vld[(prev + off) % N]) owner = (prev + off) % N;
            end
        end else if (vld[owner] && i_tready_out) begin
            xfer[owner] = 1'b1;
            if (lst[owner]) begin
                tid_order.push_back(owner);
                prev  = owner;
                pkts++;
                owner = -1;
            end
        end
    endtask

    task automatic run_cycles(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_and_step();
            @(posedge clk);
            #1;
            drive_sources();
        end
    endtask

    int exp_order[5];
    bit did_reset;

    initial begin
        clear_sources();
        model_reset();
        all_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", DW'(o_tvalid_out), '0);
        chk("rst_tready", DW'(o_tready_in), '0);
        chk("rst_busy", DW'(o_busy), '0);
        chk("rst_tid", DW'(o_tid_out), '0);
        chk("rst_tlast", DW'(o_tlast_out), '0);
        chk("rst_cnt", DW'(o_pkt_cnt), '0);
        reset_n = 1'b1;

        // Fairness: everyone always valid with 2-beat packets.
        all_valid = 1'b1;
        drive_sources();
        run_cycles(16);
        exp_order = '{0, 1, 2, 3, 0};
        chk("fair_count", DW'(tid_order.size() >= 5), DW'(1));
        for (int i = 0; i < 5 && i < tid_order.size(); i++)
            chk($sformatf("fair_order%0d", i), DW'(tid_order[i]), DW'(exp_order[i]));

        // Random traffic with stalls and backpressure, plus one mid-packet reset.
        all_valid = 1'b0;
        did_reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check_and_step();
            @(posedge clk);
            #1;
            drive_sources();
            if (!did_reset && c > 1500 && owner >= 0 && pkts > 0) begin
                did_reset = 1'b1;
                reset_n = 1'b0;
                #1;
                chk("mid_rst_tvalid", DW'(o_tvalid_out), '0);
                chk("mid_rst_tready", DW'(o_tready_in), '0);
                chk("mid_rst_busy", DW'(o_busy), '0);
                chk("mid_rst_cnt", DW'(o_pkt_cnt), '0);
                clear_sources();
                model_reset();
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                // Everyone asks at once: port 0 must win right after reset.
                tid_order.delete();
                for (int k = 0; k < N; k++) begin
                    rem[k] = 1; vld[k] = 1'b1; lst[k] = 1'b1;
                    dat[k] = rand_data(); kep[k] = {$urandom, $urandom};
                end
                apply_inputs();
                i_tready_out = 1'b1;
                run_cycles(3);
                chk("post_rst_first", DW'(tid_order.size() > 0 ? tid_order[0] : -1), DW'(0));
            end
        end
        chk("mid_rst_done", DW'(did_reset), DW'(1));
        chk("traffic_moved", DW'(pkts > 20), DW'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
